// File: rtl/ysyx_25040129_axi_sram.sv
// AXI4 slave backed by a word-addressed SRAM: read bursts with programmable
// per-beat latency and independent single-beat byte-masked writes.
module ysyx_25040129_axi_sram #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [2:0]  arsize,
    input  logic [7:0]  arlen,
    input  logic [1:0]  arburst,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        rlast,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  dbg_r_state_o
);
    // Handshakes: a transfer happens on the rising edge where valid && ready are both 1;
    // a source holds valid and its payload steady until that edge.

    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;
    localparam logic [3:0]  LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    logic [31:0] mem [DEPTH];

    r_state_e    r_state_q, r_state_d;
    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d;
    logic [1:0]  rburst_q, rburst_d;
    logic [7:0]  beat_q, beat_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic [31:0] raddr_step;
    logic [31:0] lk_addr;
    logic [31:0] lk_off;
    logic        lk_in;
    logic [IDX_W-1:0] lk_idx;
    logic [1:0]  lk_burst;
    logic [31:0] lk_word;
    logic [1:0]  lk_resp;

    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic        commit;
    logic [31:0] w_off;
    logic        w_in;
    logic [IDX_W-1:0] w_idx;

    logic        unused_bits;
    assign unused_bits = ^{arsize, lk_off[31:IDX_W+2], lk_off[1:0],
                           w_off[31:IDX_W+2], w_off[1:0]};

    // FIXED repeats the word; INCR and the unsupported encodings step by one word.
    assign raddr_step = (rburst_q == 2'b00) ? raddr_q : raddr_q + 32'd4;

    // The address whose word is registered this cycle, if any: the AR address
    // (zero latency), the next beat's address (zero latency), or the waiting beat's.
    always_comb begin
        lk_addr  = raddr_q;
        lk_burst = rburst_q;
        if (r_state_q == R_IDLE) begin
            lk_addr  = araddr;
            lk_burst = arburst;
        end else if (r_state_q == R_DATA) begin
            lk_addr = raddr_step;
        end
    end

    assign lk_off  = lk_addr - BASE_ADDR;
    assign lk_in   = {1'b0, lk_off} < SPAN;
    assign lk_idx  = lk_off[IDX_W+1:2];
    assign lk_word = lk_in ? mem[lk_idx] : 32'd0;
    assign lk_resp = lk_burst[1] ? 2'b10 : (lk_in ? 2'b00 : 2'b11);

    always_comb begin
        r_state_d = r_state_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    raddr_d  = araddr;
                    rlen_d   = arlen;
                    rburst_d = arburst;
                    beat_d   = 8'd0;
                    cnt_d    = LAT;
                    if (LAT == 4'd0) begin
                        rdata_d   = lk_word;
                        rresp_d   = lk_resp;
                        r_state_d = R_DATA;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d   = lk_word;
                    rresp_d   = lk_resp;
                    r_state_d = R_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast) begin
                        r_state_d = R_IDLE;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        raddr_d = raddr_step;
                        cnt_d   = LAT;
                        if (LAT == 4'd0) begin
                            rdata_d = lk_word;
                            rresp_d = lk_resp;
                        end else begin
                            r_state_d = R_WAIT;
                        end
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            raddr_q   <= 32'd0;
            rlen_q    <= 8'd0;
            rburst_q  <= 2'b00;
            beat_q    <= 8'd0;
            cnt_q     <= 4'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign arready       = (r_state_q == R_IDLE);
    assign rvalid        = (r_state_q == R_DATA);
    assign rlast         = (r_state_q == R_DATA) && (beat_q == rlen_q);
    assign rdata         = rdata_q;
    assign rresp         = rresp_q;
    assign dbg_r_state_o = r_state_q;

    // Write path: AW and W are captured independently, committed once both are held.
    assign commit = aw_done_q && w_done_q && !bvalid_q;
    assign w_off  = waddr_q - BASE_ADDR;
    assign w_in   = {1'b0, w_off} < SPAN;
    assign w_idx  = w_off[IDX_W+1:2];

    always_comb begin
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (bvalid_q && bready) begin
            bvalid_d  = 1'b0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
        end else begin
            if (awvalid && !aw_done_q) begin
                aw_done_d = 1'b1;
                waddr_d   = awaddr;
            end
            if (wvalid && !w_done_q) begin
                w_done_d = 1'b1;
                wdata_d  = wdata;
                wstrb_d  = wstrb;
            end
            if (commit) begin
                bvalid_d = 1'b1;
                bresp_d  = w_in ? 2'b00 : 2'b11;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            waddr_q   <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready = !aw_done_q;
    assign wready  = !w_done_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;

    // Storage is deliberately outside reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (commit && w_in) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule
